md5_match_unit: RTL

Downstream stage of the MD5 cracking pipeline: sits after `md5core` and beside `generator`, and closes the search loop. It re-times each candidate message through a delay line matched to `md5core` latency, so every hash is compared against the goal digest together with the message that produced it. It captures the first matching candidate, counts completed comparisons, and reports found or exhausted to the host.

---
 rtl/md5_pkg.sv | 25 ++
 rtl/md5_align_delay.sv | 73 +++++++
 rtl/md5_match_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/md5_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md5_pkg
// Purpose  : Constants and types shared by the MD5 cracking pipeline
//            (generator, md5core, md5_match_unit).
// Contents : HASH_W / MSG_W / LEN_W datapath widths,
//            match_state_t search-state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package md5_pkg;

    localparam int HASH_W = 128;   // digest width
    localparam int MSG_W  = 448;   // unpadded candidate message bits
    localparam int LEN_W  = 64;    // candidate length field, in bits

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        DRAIN     = 3'd2,
        FOUND     = 3'd3,
        EXHAUSTED = 3'd4
    } match_state_t;

endpackage : md5_pkg
`default_nettype wire

// File: rtl/md5_align_delay.sv
`default_nettype none
// ============================================================================
// Module   : md5_align_delay
// Purpose  : Valid/data shift register that re-times candidates so they
//            emerge in step with the md5core hash output.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            flush           - synchronous clear of every valid bit
//            in_valid/in_data  - stage 1 input
//            out_valid/out_data - stage DEPTH output (tap)
// Revision : 1.0 - initial release
// ============================================================================
module md5_align_delay #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            logic             prev_valid;
            logic [WIDTH-1:0] prev_data;
            logic [WIDTH-1:0] data_d;

            if (i == 0) begin : g_head
                assign prev_valid = in_valid;
                assign prev_data  = in_data;
            end else begin : g_body
                assign prev_valid = valid_q[i-1];
                assign prev_data  = data_q[i-1];
            end

            assign valid_d[i] = prev_valid & ~flush;

            // Data only moves with a valid token; idle slots keep stale
            // contents, which is harmless because valid gates every use.
            always_comb begin
                data_d = data_q[i];
                if (prev_valid) begin
                    data_d = prev_data;
                end
            end

            // Data needs no reset: it is never observed without its valid bit.
            always_ff @(posedge clk) begin
                data_q[i] <= data_d;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule : md5_align_delay
`default_nettype wire

// File: rtl/md5_match_unit.sv
`default_nettype none
// ============================================================================
// Module   : md5_match_unit
// Purpose  : Closes the MD5 search loop. Delays each candidate to line up
//            with its hash, compares against the goal digest, captures the
//            first match and reports found / exhausted.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            arm                   - restart search, sample goal
//            goal                  - target digest
//            cand_valid/msg/len    - candidate presented to md5core
//            gen_done              - generator finished issuing
//            hash                  - md5core output
//            busy/found/exhausted  - search status
//            found_msg/found_len   - captured matching candidate
//            attempts              - saturating compare count
// Revision : 1.0 - initial release
// ============================================================================
module md5_match_unit #(
    parameter int MSG_W   = md5_pkg::MSG_W,
    parameter int LEN_W   = md5_pkg::LEN_W,
    parameter int HASH_W  = md5_pkg::HASH_W,
    parameter int LATENCY = 64,
    parameter int CNT_W   = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic [HASH_W-1:0] goal,
    input  logic              cand_valid,
    input  logic [MSG_W-1:0]  cand_msg,
    input  logic [LEN_W-1:0]  cand_len,
    input  logic              gen_done,
    input  logic [HASH_W-1:0] hash,
    output logic              busy,
    output logic              found,
    output logic              exhausted,
    output logic [MSG_W-1:0]  found_msg,
    output logic [LEN_W-1:0]  found_len,
    output logic [CNT_W-1:0]  attempts
);

    import md5_pkg::*;

    localparam int C_DATA_W  = MSG_W + LEN_W;
    localparam int C_DRAIN_W = $clog2(LATENCY + 1);

    match_state_t         state_q, state_d;
    logic [HASH_W-1:0]    goal_q, goal_d;
    logic [CNT_W-1:0]     attempts_q, attempts_d;
    logic [MSG_W-1:0]     found_msg_q, found_msg_d;
    logic [LEN_W-1:0]     found_len_q, found_len_d;
    logic [C_DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

    logic                 accept;
    logic                 tap_valid;
    logic [C_DATA_W-1:0]  tap_data;
    logic [MSG_W-1:0]     tap_msg;
    logic [LEN_W-1:0]     tap_len;
    logic                 cmp_valid;
    logic                 match;
    logic                 drain_zero;

    // Candidates outside ARMED are never seen by the compare path.
    assign accept = cand_valid && (state_q == ARMED);

    md5_align_delay #(
        .DEPTH (LATENCY),
        .WIDTH (C_DATA_W)
    ) u_align (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (arm),
        .in_valid  (accept),
        .in_data   ({cand_msg, cand_len}),
        .out_valid (tap_valid),
        .out_data  (tap_data)
    );

    assign tap_msg    = tap_data[C_DATA_W-1:LEN_W];
    assign tap_len    = tap_data[LEN_W-1:0];
    assign cmp_valid  = tap_valid && ((state_q == ARMED) || (state_q == DRAIN));
    assign match      = cmp_valid && (hash == goal_q);
    assign drain_zero = (drain_cnt_q == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: arm > match > gen_done
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                IDLE:      state_d = IDLE;
                ARMED: begin
                    if (match) begin
                        state_d = FOUND;
                    end else if (gen_done) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (match) begin
                        state_d = FOUND;
                    end else if (drain_zero) begin
                        state_d = EXHAUSTED;
                    end
                end
                FOUND:     state_d = FOUND;
                EXHAUSTED: state_d = EXHAUSTED;
                default:   state_d = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state_q == ARMED) || (state_q == DRAIN);
        found     = (state_q == FOUND);
        exhausted = (state_q == EXHAUSTED);
    end

    // ------------------------------------------------------------------
    // Datapath: goal, attempt counter, capture, drain counter
    // ------------------------------------------------------------------
    always_comb begin
        goal_d      = goal_q;
        attempts_d  = attempts_q;
        found_msg_d = found_msg_q;
        found_len_d = found_len_q;
        drain_cnt_d = drain_cnt_q;

        if (arm) begin
            goal_d      = goal;
            attempts_d  = '0;
            found_msg_d = '0;
            found_len_d = '0;
            drain_cnt_d = '0;
        end else begin
            if (cmp_valid && (attempts_q != '1)) begin
                attempts_d = attempts_q + CNT_W'(1);
            end
            // match is only possible in ARMED/DRAIN, so this is the first one
            if (match) begin
                found_msg_d = tap_msg;
                found_len_d = tap_len;
            end
            // The drain window covers the last candidate still in the pipe,
            // including one accepted on the same cycle as gen_done.
            if ((state_q == ARMED) && !match && gen_done) begin
                drain_cnt_d = C_DRAIN_W'(LATENCY);
            end else if ((state_q == DRAIN) && !drain_zero) begin
                drain_cnt_d = drain_cnt_q - C_DRAIN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            goal_q      <= '0;
            attempts_q  <= '0;
            found_msg_q <= '0;
            found_len_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            goal_q      <= goal_d;
            attempts_q  <= attempts_d;
            found_msg_q <= found_msg_d;
            found_len_q <= found_len_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    assign found_msg = found_msg_q;
    assign found_len = found_len_q;
    assign attempts  = attempts_q;

endmodule : md5_match_unit
`default_nettype wire
